// File: rtl/npc_btb_predictor_if.sv
// Fetch/resolve bundle between the next-PC predictor and the IF/EX stages.
// The master drives EX resolution and stall. The slave (the predictor) drives the fetch PC and the statistics.
interface npc_btb_predictor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic [XLEN-1:0]  pc_o;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic             redirect_o;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output stall, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    input  pc_o, pred_taken_o, pred_target_o, redirect_o, hit_cnt_o,
           mispred_cnt_o
  );

  modport slave (
    input  stall, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    output pc_o, pred_taken_o, pred_target_o, redirect_o, hit_cnt_o,
           mispred_cnt_o
  );
endinterface

// File: rtl/npc_btb_predictor.sv
// Next-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// It redirects fetch on an EX-stage mispredict and counts lookup hits and redirects.
module npc_btb_predictor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  npc_btb_predictor_if.slave   bus
);
  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] hit_cnt_q, mispred_cnt_q;

  logic             valid_q [BTB_ENTRIES];
  logic             jump_q  [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [XLEN-1:0]  tgt_q   [BTB_ENTRIES];

  logic [IDX-1:0]   f_idx, ex_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;
  logic             f_hit, pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_cf, ex_hit, act_taken, redirect;
  logic [XLEN-1:0]  act_next;
  logic [1:0]       ctr_upd;

  always_comb begin
    f_idx       = pc_q[IDX+1:2];
    f_tag       = pc_q[XLEN-1:IDX+2];
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
    pred_target = pred_taken ? tgt_q[f_idx] : pc_q + XLEN'(4);
  end

  always_comb begin
    ex_idx    = bus.ex_pc[IDX+1:2];
    ex_tag    = bus.ex_pc[XLEN-1:IDX+2];
    ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_cf     = bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);
    act_taken = bus.ex_is_jump || (bus.ex_is_branch && bus.ex_taken);
    act_next  = act_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
    redirect  = ex_cf && ((act_taken != bus.ex_pred_taken) ||
                          (act_taken && (bus.ex_target != bus.ex_pred_target)));
    ctr_upd   = ctr_q[ex_idx];
    if (act_taken && ctr_q[ex_idx] != 2'b11)
      ctr_upd = ctr_q[ex_idx] + 2'b01;
    else if (!act_taken && ctr_q[ex_idx] != 2'b00)
      ctr_upd = ctr_q[ex_idx] - 2'b01;
  end

  always_comb begin
    pc_d = pred_target;
    if (redirect)
      pc_d = act_next;
    else if (bus.stall)
      pc_d = pc_q;
  end

  // The BTB write uses the EX index and ignores stall, so it may land on the entry being fetched this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      hit_cnt_q     <= '0;
      mispred_cnt_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (f_hit && !bus.stall && !redirect)
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (redirect)
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      if (ex_cf) begin
        if (ex_hit) begin
          ctr_q[ex_idx]  <= ctr_upd;
          jump_q[ex_idx] <= bus.ex_is_jump;
          if (act_taken)
            tgt_q[ex_idx] <= bus.ex_target;
        end else if (act_taken) begin
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
          tgt_q[ex_idx]   <= bus.ex_target;
          jump_q[ex_idx]  <= bus.ex_is_jump;
          ctr_q[ex_idx]   <= 2'b10;
        end
      end
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pred_taken_o  = pred_taken;
  assign bus.pred_target_o = pred_target;
  assign bus.redirect_o    = redirect;
  assign bus.hit_cnt_o     = hit_cnt_q;
  assign bus.mispred_cnt_o = mispred_cnt_q;
endmodule

// File: tb/tb_npc_btb_predictor.sv
// Directed vector bench for npc_btb_predictor (XLEN=32, 16 entries, RESET_PC=0).
module tb_npc_btb_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  npc_btb_predictor_if #(.XLEN(32), .CNT_W(32)) bus ();

  npc_btb_predictor #(
    .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0000_0000), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        stall, v, br, jmp, tk, ptk;
    logic [31:0] expc, tgt, ptgt;
    logic [31:0] e_pc, e_ptgt;
    logic        e_pt, e_redir;
    logic [31:0] e_hit, e_mis;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic stall, v, br, jmp,
                              input logic [31:0] expc, input logic tk,
                              input logic [31:0] tgt, input logic ptk,
                              input logic [31:0] ptgt, e_pc, input logic e_pt,
                              input logic [31:0] e_ptgt, input logic e_redir,
                              input logic [31:0] e_hit, e_mis);
    vec_t r;
    r.stall = stall; r.v = v; r.br = br; r.jmp = jmp; r.expc = expc;
    r.tk = tk; r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt; r.e_pc = e_pc;
    r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_redir = e_redir;
    r.e_hit = e_hit; r.e_mis = e_mis;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, v, br, jmp, input logic [31:0] expc,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt);
    bus.stall = stall; bus.ex_valid = v; bus.ex_is_branch = br;
    bus.ex_is_jump = jmp; bus.ex_pc = expc; bus.ex_taken = tk;
    bus.ex_target = tgt; bus.ex_pred_taken = ptk; bus.ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // stall v br jmp expc tk tgt ptk ptgt | pc pt ptgt redir hit mis
    vecs[0]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h0,  0,32'h4,  0,0,0);
    vecs[1]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h4,  0,32'h8,  0,0,0);
    vecs[2]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h8,  0,32'hC,  0,0,0);
    vecs[3]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'hC,  0,32'h10, 0,0,0);
    vecs[4]  = mk(0,1,1,0,32'h10, 1,32'h40, 0,32'h0,   32'h10, 0,32'h14, 1,0,0);
    vecs[5]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h40, 0,32'h44, 0,0,1);
    vecs[6]  = mk(0,1,0,1,32'h44, 0,32'h10, 0,32'h0,   32'h44, 0,32'h48, 1,0,1);
    vecs[7]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h10, 1,32'h40, 0,0,2);
    vecs[8]  = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h40, 0,32'h44, 0,1,2);
    vecs[9]  = mk(0,1,1,0,32'h10, 0,32'h0,  1,32'h40,  32'h44, 1,32'h10, 1,1,2);
    vecs[10] = mk(0,1,1,0,32'h10, 0,32'h0,  0,32'h14,  32'h14, 0,32'h18, 0,1,3);
    vecs[11] = mk(0,1,0,1,32'h44, 0,32'h10, 1,32'h10,  32'h18, 0,32'h1C, 0,1,3);
    vecs[12] = mk(0,1,0,1,32'h48, 0,32'h10, 1,32'h14,  32'h1C, 0,32'h20, 1,1,3);
    vecs[13] = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h10, 0,32'h14, 0,1,4);
    vecs[14] = mk(1,1,1,0,32'h14, 1,32'h80, 0,32'h0,   32'h14, 0,32'h18, 1,2,4);
    vecs[15] = mk(1,1,0,1,32'h60, 0,32'h14, 0,32'h0,   32'h80, 0,32'h84, 1,2,5);
    vecs[16] = mk(1,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h14, 1,32'h80, 0,2,6);
    vecs[17] = mk(1,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h14, 1,32'h80, 0,2,6);
    vecs[18] = mk(1,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h14, 1,32'h80, 0,2,6);
    vecs[19] = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h14, 1,32'h80, 0,2,6);
    vecs[20] = mk(0,1,0,1,32'h100,0,32'h200,0,32'h0,   32'h80, 0,32'h84, 1,3,6);
    vecs[21] = mk(0,1,0,1,32'h140,0,32'h300,0,32'h0,   32'h200,0,32'h204,1,3,7);
    vecs[22] = mk(0,1,1,0,32'h88, 1,32'h100,0,32'h0,   32'h300,0,32'h304,1,3,8);
    vecs[23] = mk(0,0,0,0,32'h0,  0,32'h0,  0,32'h0,   32'h100,0,32'h104,0,3,9);

    idle();
    rst = 1'b1;
    @(negedge clk);
    #1 chk("reset pc", bus.pc_o, 32'h0);
    chk("reset hit_cnt", bus.hit_cnt_o, 32'h0);
    chk("reset mispred_cnt", bus.mispred_cnt_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].v, vecs[i].br, vecs[i].jmp, vecs[i].expc,
            vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      chk($sformatf("v%0d pc", i), bus.pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d pred_taken", i), 32'(bus.pred_taken_o), 32'(vecs[i].e_pt));
      chk($sformatf("v%0d pred_target", i), bus.pred_target_o, vecs[i].e_ptgt);
      chk($sformatf("v%0d redirect", i), 32'(bus.redirect_o), 32'(vecs[i].e_redir));
      chk($sformatf("v%0d hit_cnt", i), bus.hit_cnt_o, vecs[i].e_hit);
      chk($sformatf("v%0d mispred_cnt", i), bus.mispred_cnt_o, vecs[i].e_mis);
      @(negedge clk);
    end

    // Move to 0x200, leave an allocating update pending, then reset before the edge.
    drive(0,1,0,1,32'h104,0,32'h200,0,32'h0);
    #1 chk("jal 0x104 redirect", 32'(bus.redirect_o), 32'h1);
    @(negedge clk);
    drive(0,1,1,0,32'h200,1,32'h240,1,32'h240);
    #1 chk("pre-reset pc", bus.pc_o, 32'h200);
    chk("pre-reset mispred_cnt", bus.mispred_cnt_o, 32'd10);
    rst = 1'b1;
    #1 chk("async reset pc", bus.pc_o, 32'h0);
    chk("async reset hit_cnt", bus.hit_cnt_o, 32'h0);
    chk("async reset mispred_cnt", bus.mispred_cnt_o, 32'h0);
    chk("async reset pred_taken", 32'(bus.pred_taken_o), 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1 chk("post-reset pc", bus.pc_o, 32'h0);
    drive(0,1,0,1,32'h4,0,32'h200,0,32'h0);
    #1 chk("jal 0x4 redirect", 32'(bus.redirect_o), 32'h1);
    @(negedge clk);
    idle();
    #1 chk("fetch 0x200 pc", bus.pc_o, 32'h200);
    chk("fetch 0x200 pred_taken", 32'(bus.pred_taken_o), 32'h0);
    chk("fetch 0x200 pred_target", bus.pred_target_o, 32'h204);
    chk("fetch 0x200 mispred_cnt", bus.mispred_cnt_o, 32'h1);

    // The sequential next PC wraps from the top of the address space.
    @(negedge clk);
    drive(0,1,0,1,32'h8,0,32'hFFFF_FFFC,0,32'h0);
    @(negedge clk);
    idle();
    #1 chk("wrap pc", bus.pc_o, 32'hFFFF_FFFC);
    chk("wrap pred_target", bus.pred_target_o, 32'h0);
    @(negedge clk);
    #1 chk("wrapped pc", bus.pc_o, 32'h0);
    chk("final hit_cnt", bus.hit_cnt_o, 32'h0);
    chk("final mispred_cnt", bus.mispred_cnt_o, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/npc_btb_predictor.md
Name: npc_btb_predictor

Overview:
- Parametrised next-PC generator: owns the fetch PC register and replaces fixed PC+4 sequencing with a direct-mapped branch target buffer (BTB) using 2-bit saturating counters.
- Redirects fetch when the EX stage resolves a branch or jump that disagrees with the prediction made at fetch.
- Sits between the IF stage (drives instruction memory address) and the EX stage (consumes resolution). Also keeps hit and mispredict performance counters.

Parameters:
- XLEN, 32, datapath and PC width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC; a redirect overrides it.
- ex_valid  in  1  EX stage holds a valid resolved control-flow instruction.
- ex_is_branch  in  1  resolved instruction is a conditional branch (B type).
- ex_is_jump  in  1  resolved instruction is JAL or JALR (always taken).
- ex_pc  in  XLEN  PC of the resolved instruction.
- ex_taken  in  1  actual outcome; ignored unless ex_is_branch.
- ex_target  in  XLEN  actual target (PC+IMM for B/JAL, ALU result for JALR).
- ex_pred_taken  in  1  prediction carried down the pipeline for this instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipeline.
- pc_o  out  XLEN  current fetch PC.
- pred_taken_o  out  1  fetch-stage prediction for pc_o.
- pred_target_o  out  XLEN  predicted next PC for pc_o.
- redirect_o  out  1  combinational mispredict flag; pipeline flushes IF/ID.
- hit_cnt_o  out  CNT_W  count of BTB lookup hits.
- mispred_cnt_o  out  CNT_W  count of redirects.

Behaviour:

Reset:
- pc_o = RESET_PC.
- All entry valid bits and jump flags are 0; all counters are 2'b01.
- Both performance counters are 0.
- Reset is honoured mid-operation; no pending update survives it.

Fetch lookup (combinational on pc_o):
- Index = pc_o[IDX+1:2]; tag = pc_o[XLEN-1:IDX+2].
- hit = valid & tag match.
- pred_taken_o = hit & (jump flag | counter[1]).
- pred_target_o = pred_taken_o ? stored target : pc_o+4, computed modulo 2^XLEN so the PC wraps.

Resolution (combinational):
- act_taken = ex_is_jump | (ex_is_branch & ex_taken).
- act_next = act_taken ? ex_target : ex_pc+4.
- redirect_o = ex_valid & (ex_is_branch | ex_is_jump) & ((act_taken != ex_pred_taken) | (act_taken & ex_target != ex_pred_target)).

PC update priority, 1-cycle latency:
- rst > redirect_o > stall > predict.
- Redirect: pc_o <= act_next.
- Stall: pc_o holds.
- Predict: pc_o <= pred_target_o.
- When redirect and stall occur in the same cycle, the redirect wins.

BTB update on the clock edge when ex_valid & (ex_is_branch | ex_is_jump), regardless of stall:
- On a tag hit at the ex_pc index: the counter saturates up if act_taken and down otherwise (11 stays 11, 00 stays 00). The target is rewritten with ex_target if act_taken; the jump flag is set to ex_is_jump.
- On a miss with act_taken: allocate the entry, overwriting any occupant. Set valid, tag, target and jump flag; counter = 2'b10.
- On a miss with not taken: no allocation, no state change.
- Same-cycle lookup reads the pre-update contents; there is no bypass.
- Low PC bits [1:0] are not stored; the target is stored at full width.

Performance counters:
- hit_cnt_o increments on a fetch-lookup hit when stall is 0 and redirect_o is 0.
- mispred_cnt_o increments on each redirect_o cycle.
- Both counters wrap modulo 2^CNT_W.

Test Plan:
- Reset then 3 cycles with no ex_valid -> pc_o = 0, 4, 8, 0xC; pred_taken_o = 0; both counters 0.
- ex_valid, ex_is_branch, ex_pc=0x10, ex_taken=1, ex_target=0x40, ex_pred_taken=0 -> redirect_o=1 that cycle; next pc_o = 0x40; mispred_cnt_o = 1. On a later fetch at 0x10: pred_taken_o=1, pred_target_o=0x40, next pc_o = 0x40.
- Branch at 0x10 resolved not-taken twice with the prediction matching the counter each time -> counter 10 then 01; the second resolution causes no redirect. The fetch at 0x10 then predicts 0x14.
- stall=1 with redirect active in the same cycle (ex_target=0x80) -> pc_o = 0x80 next cycle. With stall=1 and no redirect -> pc_o holds for 3 cycles; hit_cnt_o unchanged.
- Aliasing with BTB_ENTRIES=16: a JAL at 0x100 to 0x200 is allocated, then a JAL at 0x140 to 0x300 (same index) -> the entry is replaced; a fetch at 0x100 misses and predicts 0x104.
- Assert rst while pc_o=0x200 and an update is pending -> pc_o = RESET_PC immediately; a later fetch at 0x200 misses; counters read 0.
